// File: rtl/riscv_mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto one single-port memory.
// Data wins by default; RISCV_ARB_STARVE_EN adds fetch anti-starvation.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   if_req/if_addr      fetch request (held until if_gnt)
//   if_gnt              fetch accepted this cycle
//   if_rvalid/if_rdata  fetch read data, one cycle after if_gnt
//   d_req/d_we/d_addr   data request (held until d_gnt)
//   d_wdata             store data
//   d_gnt               data accepted this cycle
//   d_rvalid/d_rdata    load data, one cycle after a load d_gnt
//   mem_en/mem_we       memory strobe / write enable
//   mem_addr/mem_wdata  memory byte address / write data
//   mem_rdata           memory read data, one cycle after a read strobe
//
// Macro RISCV_ARB_STARVE_EN: after STARVE_MAX consecutive fetch
// denials, fetch beats data until it is granted.

module riscv_mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (STARVE_MAX < 1) begin : g_bad_cfg
    $error("STARVE_MAX must be at least 1");
  end

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  owner_e owner_q;
  owner_e owner_d;

  logic fetch_pri;
  logic gnt_i;
  logic gnt_d;

`ifdef RISCV_ARB_STARVE_EN
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;

  // Fetch has waited long enough: it wins the next conflict.
  assign fetch_pri = (starve_q == SW'(STARVE_MAX));
`else
  assign fetch_pri = 1'b0;
`endif

  // Grant decision. Reset masks both grants so nothing reaches
  // the memory while rst is high.
  always_comb begin
    gnt_d = 1'b0;
    gnt_i = 1'b0;
    if (!rst) begin
      gnt_d = d_req && !(if_req && fetch_pri);
      gnt_i = if_req && !gnt_d;
    end
  end

  assign if_gnt = gnt_i;
  assign d_gnt  = gnt_d;

  // Memory side: the granted access goes out in the same cycle.
  assign mem_en    = gnt_i || gnt_d;
  assign mem_we    = gnt_d && d_we;
  assign mem_addr  = gnt_d ? d_addr : if_addr;
  assign mem_wdata = d_wdata;

  // Owner of the read that is in flight; stores own nothing.
  always_comb begin
    owner_d = OWN_NONE;
    if (rst) begin
      owner_d = OWN_NONE;
    end else if (gnt_i) begin
      owner_d = OWN_FETCH;
    end else if (gnt_d && !d_we) begin
      owner_d = OWN_DATA;
    end
  end

`ifdef RISCV_ARB_STARVE_EN
  // Count consecutive fetch denials, saturating at STARVE_MAX.
  always_comb begin
    starve_d = starve_q;
    if (rst || gnt_i) begin
      starve_d = '0;
    end else if (if_req && !fetch_pri) begin
      starve_d = starve_q + SW'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= OWN_NONE;
`ifdef RISCV_ARB_STARVE_EN
      starve_q <= '0;
`endif
    end else begin
      owner_q  <= owner_d;
`ifdef RISCV_ARB_STARVE_EN
      starve_q <= starve_d;
`endif
    end
  end

  // A read issued just before reset rises still has owner_q set;
  // masking with rst drops its response.
  assign if_rvalid = !rst && (owner_q == OWN_FETCH);
  assign d_rvalid  = !rst && (owner_q == OWN_DATA);

  assign if_rdata = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter.
// Directed scenarios plus randomized traffic against a reference model.

module tb_riscv_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;
  localparam int NW   = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  riscv_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory device attached to the arbiter.
  logic [DW-1:0] dev_mem [NW];
  logic [DW-1:0] dev_rd;
  assign mem_rdata = dev_rd;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) dev_mem[mem_addr[5:2]] <= mem_wdata;
      else        dev_rd <= dev_mem[mem_addr[5:2]];
    end
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: data wins unless fetch has been denied
  // SMAX times in a row (anti-starvation build only).
  logic [DW-1:0] ref_mem [NW];
  int  denials  = 0;
  bit  pend_i   = 0;
  bit  pend_d   = 0;
  logic [DW-1:0] pend_val;
  bit  gi_seen  = 0;
  bit  gd_seen  = 0;

  always @(negedge clk) begin
    bit e_i;
    bit e_d;
    bit win;
    if (rst) begin
      chk("rst_if_gnt", if_gnt, 0);
      chk("rst_d_gnt", d_gnt, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_if_rvalid", if_rvalid, 0);
      chk("rst_d_rvalid", d_rvalid, 0);
      denials = 0;
      pend_i  = 0;
      pend_d  = 0;
    end else begin
      chk("m_if_rvalid", if_rvalid, pend_i);
      chk("m_d_rvalid", d_rvalid, pend_d);
      if (pend_i) chk("m_if_rdata", if_rdata, pend_val);
      if (pend_d) chk("m_d_rdata", d_rdata, pend_val);
`ifdef RISCV_ARB_STARVE_EN
      win = (denials >= SMAX);
`else
      win = 0;
`endif
      e_d = d_req && !(if_req && win);
      e_i = if_req && !e_d;
      chk("m_if_gnt", if_gnt, e_i);
      chk("m_d_gnt", d_gnt, e_d);
      chk("m_mem_en", mem_en, e_i || e_d);
      chk("m_mem_we", mem_we, e_d && d_we);
      if (e_d) chk("m_addr_d", mem_addr, d_addr);
      if (e_i) chk("m_addr_i", mem_addr, if_addr);
      if (e_d && d_we) chk("m_wdata", mem_wdata, d_wdata);
      pend_i = e_i;
      pend_d = e_d && !d_we;
      if (e_i) pend_val = ref_mem[if_addr[5:2]];
      if (e_d && !d_we) pend_val = ref_mem[d_addr[5:2]];
      if (e_d && d_we) ref_mem[d_addr[5:2]] = d_wdata;
      if (e_i) denials = 0;
      else if (if_req && denials < SMAX) denials++;
    end
    gi_seen = if_gnt;
    gd_seen = d_gnt;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req = 0;
    d_req  = 0;
    d_we   = 0;
  endtask

  int g;
  int rv;
  bit got_i;
  bit got_d;

  initial begin
    for (int i = 0; i < NW; i++) begin
      dev_mem[i] = $urandom;
      ref_mem[i] = dev_mem[i];
    end
    dev_mem[2] = 32'h0000_0013;
    ref_mem[2] = 32'h0000_0013;
    dev_mem[3] = 32'd42;
    ref_mem[3] = 32'd42;
    dev_rd  = '0;
    rst     = 1;
    if_req  = 1;
    d_req   = 1;
    d_we    = 0;
    if_addr = 32'h4;
    d_addr  = 32'h4;
    d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_gnts", {if_gnt, d_gnt, mem_en}, 0);

    // Fetch-only read, first cycle after reset falls.
    step();
    rst = 0;
    d_req = 0;
    if_addr = 32'h8;
    @(negedge clk);
    chk("fetch_gnt", if_gnt, 1);
    chk("fetch_addr", mem_addr, 32'h8);
    step();
    idle();
    @(negedge clk);
    chk("fetch_rvalid", if_rvalid, 1);
    chk("fetch_rdata", if_rdata, 32'h13);

    // Simultaneous requests: data wins, fetch waits.
    step();
    if_req = 1;
    if_addr = 32'h8;
    d_req = 1;
    d_we = 0;
    d_addr = 32'hC;
    @(negedge clk);
    chk("sim_d_gnt", d_gnt, 1);
    chk("sim_if_gnt", if_gnt, 0);
    step();
    d_req = 0;
    @(negedge clk);
    chk("sim_d_rvalid", d_rvalid, 1);
    chk("sim_d_rdata", d_rdata, 42);
    chk("sim_no_if_rv", if_rvalid, 0);
    step();
    idle();
    @(negedge clk);

    // Store, then load back.
    step();
    d_req = 1;
    d_we = 1;
    d_addr = 32'h8;
    d_wdata = 77;
    @(negedge clk);
    chk("st_mem_we", mem_we, 1);
    chk("st_mem_addr", mem_addr, 32'h8);
    step();
    d_we = 0;
    @(negedge clk);
    chk("st_no_rvalid", {if_rvalid, d_rvalid}, 0);
    step();
    idle();
    @(negedge clk);
    chk("ld_rvalid", d_rvalid, 1);
    chk("ld_rdata", d_rdata, 77);

    // Starvation: both held for six cycles.
    step();
    d_req = 1;
    d_we = 0;
    d_addr = 32'h0;
    if_req = 1;
    if_addr = 32'h4;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
`ifdef RISCV_ARB_STARVE_EN
      chk("starve_if", if_gnt, (k == 5));
`else
      chk("starve_if", if_gnt, 0);
`endif
      step();
    end
    idle();
    @(negedge clk);

    // Reset in the cycle after a fetch grant.
    step();
    if_req = 1;
    if_addr = 32'h4;
    @(negedge clk);
    chk("rmid_gnt", if_gnt, 1);
    step();
    rst = 1;
    d_req = 1;
    @(negedge clk);
    chk("rmid_rvalid", if_rvalid, 0);
    chk("rmid_outs",
        {if_gnt, d_gnt, mem_en, mem_we, d_rvalid}, 0);
    step();
    @(negedge clk);
    step();
    rst = 0;
    d_req = 0;
    @(negedge clk);
    chk("rmid_first", if_gnt, 1);
    step();
    idle();
    @(negedge clk);

    // Throughput: alternating loads and fetches.
    g  = 0;
    rv = 0;
    for (int k = 0; k < 9; k++) begin
      step();
      idle();
      if (k < 8) begin
        if (k % 2 == 0) begin
          d_req = 1;
          d_addr = 32'(k * 4);
        end else begin
          if_req = 1;
          if_addr = 32'(k * 4);
        end
      end
      @(negedge clk);
      chk("tput_excl", if_gnt && d_gnt, 0);
      if (if_gnt || d_gnt) g++;
      if (k > 0 && (k % 2 == 1)) chk("tput_d_rv", d_rvalid, 1);
      if (k > 0 && (k % 2 == 0)) chk("tput_i_rv", if_rvalid, 1);
      if (if_rvalid || d_rvalid) rv++;
    end
    chk("tput_gnts", g, 8);
    chk("tput_rvalids", rv, 8);

    // Randomized traffic, requests held until granted.
    for (int c = 0; c < 3000; c++) begin
      got_i = gi_seen;
      got_d = gd_seen;
      step();
      rst = ($urandom_range(0, 99) == 0);
      if (!if_req || got_i) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = {26'(0), 4'($urandom_range(0, 15)), 2'b00};
      end
      if (!d_req || got_d) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = $urandom_range(0, 1);
        d_addr  = {26'(0), 4'($urandom_range(0, 15)), 2'b00};
        d_wdata = $urandom;
      end
      @(negedge clk);
    end

    step();
    rst = 0;
    idle();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks",
             n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/riscv_mem_arbiter.md
RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 32, address width of all ports.
REQ-002 The module SHALL have parameter DATA_W, default 32, data width of all ports.
REQ-003 The module SHALL have parameter STARVE_MAX, default 4, maximum consecutive fetch denials before fetch gets priority.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 if_req  input  1  instruction-fetch request.
REQ-007 if_addr  input  ADDR_W  fetch byte address.
REQ-008 if_gnt  output  1  fetch request accepted this cycle.
REQ-009 if_rvalid  output  1  if_rdata valid.
REQ-010 if_rdata  output  DATA_W  fetched instruction word.
REQ-011 d_req  input  1  data-access request.
REQ-012 d_we  input  1  1 = store, 0 = load.
REQ-013 d_addr  input  ADDR_W  data byte address.
REQ-014 d_wdata  input  DATA_W  store data.
REQ-015 d_gnt  output  1  data request accepted this cycle.
REQ-016 d_rvalid  output  1  d_rdata valid (loads only).
REQ-017 d_rdata  output  DATA_W  load data.
REQ-018 mem_en  output  1  single-port memory access strobe.
REQ-019 mem_we  output  1  memory write enable.
REQ-020 mem_addr  output  ADDR_W  memory byte address (memory indexes by addr >> 2).
REQ-021 mem_wdata  output  DATA_W  memory write data.
REQ-022 mem_rdata  input  DATA_W  memory read data, valid one cycle after a read strobe.

Function
REQ-023 The arbiter SHALL grant at most one requester per cycle; if_gnt and d_gnt are never both 1.
REQ-024 Grant SHALL be combinational from the requests and registered state; the access appears on mem_en/mem_we/mem_addr/mem_wdata in the same cycle.
REQ-025 Default priority SHALL be data over fetch.
REQ-026 mem_we SHALL equal d_we when d_gnt = 1, and SHALL be 0 otherwise; mem_en SHALL be 0 when neither request is granted.
REQ-027 Read latency SHALL be 1 cycle: a granted read at cycle N yields rvalid = 1 for exactly one cycle at N+1, on the owner's port only.
REQ-028 A registered owner field (NONE/FETCH/DATA) SHALL record the read issued in the previous cycle and steer mem_rdata to if_rdata or d_rdata.
REQ-029 Granted stores SHALL produce no rvalid; the owner for the next cycle is NONE.
REQ-030 Back-to-back grants SHALL be allowed every cycle, giving one access per cycle at full throughput.
REQ-031 Requesters SHALL hold req and address/data stable until gnt; the arbiter does not buffer requests.
REQ-032 The starve counter (width clog2(STARVE_MAX+1)) SHALL increment when if_req = 1 and if_gnt = 0, reset to 0 on if_gnt, hold when if_req = 0, and saturate at STARVE_MAX.
REQ-033 Outputs if_rdata and d_rdata SHALL be don't-care when the matching rvalid is 0.

Reset
REQ-034 While rst = 1, the block SHALL drive if_gnt, d_gnt, mem_en, mem_we, if_rvalid and d_rvalid to 0, set owner to NONE, and set the starve counter to 0.
REQ-035 A read granted in the cycle before rst rises SHALL NOT produce rvalid.
REQ-036 The first grant SHALL be possible in the first cycle after rst falls.

Configuration
REQ-037 With macro RISCV_ARB_STARVE_EN defined, fetch SHALL take priority over data in any cycle where the starve counter equals STARVE_MAX and both requests are present.
REQ-038 Without RISCV_ARB_STARVE_EN, priority SHALL be strict data-over-fetch, and the starve counter SHALL be absent.

Verification
REQ-039 Fetch-only read: if_req = 1, if_addr = 0x8, mem[2] = 0x0000_0013 -> if_gnt = 1 at cycle N; if_rvalid = 1 with if_rdata = 0x13 at N+1.
REQ-040 Simultaneous requests: if_req = d_req = 1, d_we = 0, d_addr = 0xC, mem[3] = 42 -> d_gnt = 1 and if_gnt = 0; d_rvalid = 1 with d_rdata = 42 next cycle; no if_rvalid.
REQ-041 Store: d_req = 1, d_we = 1, d_addr = 0x8, d_wdata = 77 -> mem_we = 1 and mem_addr = 0x8 in the same cycle; no rvalid; a later load from 0x8 returns 77.
REQ-042 Starvation with RISCV_ARB_STARVE_EN: d_req and if_req held at 1 -> d_gnt for 4 cycles, then if_gnt on cycle 5, then d_gnt again; without the macro, d_gnt every cycle.
REQ-043 Reset mid-read: fetch granted at cycle N, rst = 1 at N+1 -> if_rvalid = 0 at N+1, all outputs 0 during reset, and the first grant occurs the cycle after rst falls.
REQ-044 Throughput: alternating d_req (loads) and if_req over 8 cycles -> 8 grants, 8 rvalids each one cycle later on the correct port, and never two grants in the same cycle.
